banked_ram: RTL

Parametrised, banked, byte-writable synchronous RAM; the next generation of the team's fixed 256x32 four-bank RAM. Address MSBs select one of BANKS banks. Each access uses a Req/Ready handshake, reads are registered with a Valid strobe, and every location is zero-filled by a hardware INIT sweep after reset. It sits between the datapath/load-store unit and the memory array and replaces the tri-state bank multiplexing with a registered one-hot output mux.

---
 rtl/banked_ram_pkg.sv | 29 ++
 rtl/banked_ram_bank.sv | 35 +++
 rtl/banked_ram.sv | 137 +++++++++++++
 3 files changed

// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg: shared types and default geometry for banked_ram.
// Holds the FSM state type, a clog2 helper and derived default constants.
package banked_ram_pkg;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_BANKS  = 4;

    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
    localparam int DEF_ROWS   = DEF_DEPTH / DEF_BANKS;
    localparam int DEF_BSEL_W = clog2(DEF_BANKS);
    localparam int DEF_ROW_W  = DEF_ADDR_W - DEF_BSEL_W;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank: one ROWS x DATA_W bank, byte-writable, registered read, no reset.
// Ports: CLK, row, wdata, be (per byte), we (write strobe), re (read strobe), rdata.
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROW_W  = DEF_ROW_W
) (
    input  logic                  CLK,
    input  logic [ROW_W-1:0]      row,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BW = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ROW_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int i = 0; i < BW; i++) begin
                if (be[i]) begin
                    mem[row][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[row];
        end
    end

endmodule

// File: rtl/banked_ram.sv
// banked_ram: banked byte-writable RAM with zero-fill INIT sweep after reset.
// Ports: CLK, RSTn (sync, active low), Req/RW/Addr/DataIn/ByteEn in; Ready/DataOut/Valid/InitDone out.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANKS  = DEF_BANKS
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  Req,
    input  logic                  RW,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic [DATA_W-1:0]     DataIn,
    input  logic [DATA_W/8-1:0]   ByteEn,
    output logic                  Ready,
    output logic [DATA_W-1:0]     DataOut,
    output logic                  Valid,
    output logic                  InitDone
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ROWS   = DEPTH / BANKS;
    localparam int BSEL_W = clog2(BANKS);
    localparam int ROW_W  = ADDR_W - BSEL_W;
    localparam int BE_W   = DATA_W / 8;

    state_t             state_q;
    state_t             state_d;
    logic [ROW_W-1:0]   cnt_q;
    logic [ROW_W-1:0]   cnt_d;

    logic [BSEL_W-1:0]  bsel;
    logic [ROW_W-1:0]   arow;
    logic [BANKS-1:0]   bdec;

    logic [ROW_W-1:0]   b_row;
    logic [DATA_W-1:0]  b_wdata;
    logic [BE_W-1:0]    b_be;
    logic [BANKS-1:0]   b_we;
    logic [BANKS-1:0]   b_re;
    logic [DATA_W-1:0]  bank_rdata [BANKS];

    logic               rd_pend_q;
    logic [BANKS-1:0]   rsel_q;
    logic [DATA_W-1:0]  mux_out;

    assign bsel = Addr[ADDR_W-1 -: BSEL_W];
    assign arow = Addr[ROW_W-1:0];
    assign bdec = BANKS'(1) << bsel;

    // INIT drives every bank with the sweep row; IDLE routes the request
    // strobe only to the addressed bank.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_row   = arow;
        b_wdata = DataIn;
        b_be    = ByteEn;
        b_we    = '0;
        b_re    = '0;
        unique case (state_q)
            INIT: begin
                b_row   = cnt_q;
                b_wdata = '0;
                b_be    = '1;
                b_we    = '1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ROW_W'(ROWS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (Req && RW) begin
                    b_we = bdec;
                end
                if (Req && !RW) begin
                    b_re = bdec;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            Ready     <= 1'b0;
            InitDone  <= 1'b0;
            rd_pend_q <= 1'b0;
            Valid     <= 1'b0;
            DataOut   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            Ready     <= (state_d == IDLE);
            InitDone  <= (state_d == IDLE);
            rd_pend_q <= |b_re;
            Valid     <= rd_pend_q;
            if (rd_pend_q) begin
                DataOut <= mux_out;
            end
        end
    end

    // Remembers which bank owns the read in flight; only used while
    // rd_pend_q is set, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (|b_re) begin
            rsel_q <= bdec;
        end
    end

    always_comb begin
        mux_out = '0;
        for (int b = 0; b < BANKS; b++) begin
            mux_out = mux_out | (bank_rdata[b] & {DATA_W{rsel_q[b]}});
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .CLK   (CLK),
            .row   (b_row),
            .wdata (b_wdata),
            .be    (b_be),
            .we    (b_we[g]),
            .re    (b_re[g]),
            .rdata (bank_rdata[g])
        );
    end

endmodule
